// File: rtl/multdiv_pkg.sv
// Shared op encodings and FSM state encoding for the iterative multiply/divide unit.
// Imported by the unit, its control-side users and the bench.
package multdiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } state_e;

endpackage

// File: rtl/multdiv_if.sv
// Request/result bundle between the control unit (master) and the multiply/divide unit (slave).
// Start is only honoured while Busy is low; there is no queueing behind it.
interface multdiv_if #(parameter int WIDTH = 32) ();
    logic             Start;
    logic [1:0]       Op;
    logic [WIDTH-1:0] RegA;
    logic [WIDTH-1:0] RegB;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;
    logic             Busy;
    logic             Done;
    logic             divide_by_zero;

    modport master (output Start, Op, RegA, RegB,
                    input  Hi, Lo, Busy, Done, divide_by_zero);
    modport slave  (input  Start, Op, RegA, RegB,
                    output Hi, Lo, Busy, Done, divide_by_zero);
endinterface

// File: rtl/multdiv_negate.sv
// Conditional two's-complement, purely combinational (zero latency, no handshake).
// Used both for operand magnitudes and for result sign fix-up.
module multdiv_negate #(parameter int WIDTH = 32) (
    input  logic [WIDTH-1:0] val_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] res_o
);
    assign res_o = neg_i ? (~val_i + WIDTH'(1)) : val_i;
endmodule

// File: rtl/multdiv_seq.sv
// Iterative MIPS-style multiply/divide: WIDTH+1 cycles from accepted Start to Done (1 for divide-by-zero).
// Busy high while working; Start while Busy is ignored, so the issuer must stall until Done.
module multdiv_seq
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic      Clk,
    input  logic      Reset,
    multdiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               div_q, div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               zdiv_q, zdiv_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               dbz_q, dbz_d;
    logic               done_q, done_d;
    logic               busy;

    logic               in_signed, in_div, in_zdiv;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     sum, rem_shift;
    logic [WIDTH-1:0]   addend;
    logic               q_bit;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign in_signed = ~bus.Op[0];
    assign in_div    = bus.Op[1];
    assign in_zdiv   = in_div && (bus.RegB == '0);

    // A MIN_INT magnitude is 2^(WIDTH-1), which is exact as an unsigned WIDTH-bit value.
    multdiv_negate #(.WIDTH(WIDTH)) u_mag_a (
        .val_i(bus.RegA), .neg_i(in_signed & bus.RegA[WIDTH-1]), .res_o(mag_a));
    multdiv_negate #(.WIDTH(WIDTH)) u_mag_b (
        .val_i(bus.RegB), .neg_i(in_signed & bus.RegB[WIDTH-1]), .res_o(mag_b));
    multdiv_negate #(.WIDTH(2*WIDTH)) u_fix_prod (
        .val_i(acc_q), .neg_i(neg_res_q), .res_o(prod_fix));
    multdiv_negate #(.WIDTH(WIDTH)) u_fix_quo (
        .val_i(acc_q[WIDTH-1:0]), .neg_i(neg_res_q), .res_o(quo_fix));
    multdiv_negate #(.WIDTH(WIDTH)) u_fix_rem (
        .val_i(rem_q), .neg_i(neg_rem_q), .res_o(rem_fix));

    // Shift-add step: low half of acc holds the remaining multiplier bits.
    assign addend = acc_q[0] ? opnd_q : '0;
    assign sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};

    // Restoring step: a set top bit means the trial subtract cannot go negative.
    assign rem_shift = {rem_q, acc_q[WIDTH-1]};
    assign q_bit     = rem_shift[WIDTH] | (rem_shift[WIDTH-1:0] >= opnd_q);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.Start) state_d = in_zdiv ? S_FIX : S_RUN;
            S_RUN:   if (cnt_q == CW'(1)) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
    end

    always_comb begin
        cnt_d     = cnt_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        div_d     = div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        zdiv_d    = zdiv_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dbz_d     = dbz_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: if (bus.Start) begin
                cnt_d     = CW'(WIDTH);
                opnd_d    = in_div ? mag_b : mag_a;
                acc_d     = {{WIDTH{1'b0}}, (in_div ? mag_a : mag_b)};
                rem_d     = '0;
                div_d     = in_div;
                neg_res_d = in_signed & (bus.RegA[WIDTH-1] ^ bus.RegB[WIDTH-1]);
                neg_rem_d = in_signed & bus.RegA[WIDTH-1];
                zdiv_d    = in_zdiv;
                dbz_d     = 1'b0;
            end
            S_RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (div_q) begin
                    acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], q_bit};
                    rem_d = q_bit ? (rem_shift[WIDTH-1:0] - opnd_q) : rem_shift[WIDTH-1:0];
                end else begin
                    acc_d = {sum, acc_q[WIDTH-1:1]};
                end
            end
            S_FIX: begin
                done_d = 1'b1;
                if (zdiv_q) begin
                    dbz_d = 1'b1;
                end else if (div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q     <= '0;
            opnd_q    <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            div_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            zdiv_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            dbz_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            div_q     <= div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            zdiv_q    <= zdiv_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            dbz_q     <= dbz_d;
            done_q    <= done_d;
        end
    end

    assign bus.Hi             = hi_q;
    assign bus.Lo             = lo_q;
    assign bus.Busy           = busy;
    assign bus.Done           = done_q;
    assign bus.divide_by_zero = dbz_q;

endmodule

// File: tb/tb_multdiv_seq.sv
// Directed and random checks of multdiv_seq against an arithmetic reference model.
module tb_multdiv_seq;
    import multdiv_pkg::*;

    localparam int W = 32;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    multdiv_if #(.WIDTH(W)) bus ();
    multdiv_seq #(.WIDTH(W)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0] exp_hi, exp_lo;
    logic         exp_dbz;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero with dividend-signed remainder.
    task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint      sa, sb, sp, q, r;
        logic [63:0] up;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            2'b00: begin sp = sa * sb; {exp_hi, exp_lo} = sp; exp_dbz = 1'b0; end
            2'b01: begin up = {32'b0, a} * {32'b0, b}; {exp_hi, exp_lo} = up; exp_dbz = 1'b0; end
            2'b10: begin
                if (b == '0) exp_dbz = 1'b1;
                else begin
                    q = sa / sb; r = sa % sb;
                    exp_lo = q[W-1:0]; exp_hi = r[W-1:0]; exp_dbz = 1'b0;
                end
            end
            default: begin
                if (b == '0) exp_dbz = 1'b1;
                else begin exp_lo = a / b; exp_hi = a % b; exp_dbz = 1'b0; end
            end
        endcase
    endtask

    // Called at a negedge; raises Start immediately, so back-to-back calls start in the Done cycle.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int intr, input string tag);
        int cyc;
        int exp_lat;
        model(op, a, b);
        exp_lat = (op[1] && b == '0) ? 1 : W + 1;
        bus.Start = 1'b1; bus.Op = op; bus.RegA = a; bus.RegB = b;
        @(negedge Clk);
        bus.Start = 1'b0; bus.Op = 2'($urandom); bus.RegA = W'($urandom); bus.RegB = W'($urandom);
        chk({tag, ".busy"}, 64'(bus.Busy), 64'd1);
        chk({tag, ".done_pulse"}, 64'(bus.Done), 64'd0);
        cyc = 0;
        while (!bus.Done && cyc < 200) begin
            if (cyc == intr) begin bus.Start = 1'b1; bus.Op = 2'b11; end
            else bus.Start = 1'b0;
            @(negedge Clk);
            cyc++;
        end
        bus.Start = 1'b0;
        chk({tag, ".latency"}, 64'(cyc), 64'(exp_lat));
        chk({tag, ".hi"}, 64'(bus.Hi), 64'(exp_hi));
        chk({tag, ".lo"}, 64'(bus.Lo), 64'(exp_lo));
        chk({tag, ".dbz"}, 64'(bus.divide_by_zero), 64'(exp_dbz));
        chk({tag, ".busy_end"}, 64'(bus.Busy), 64'd0);
    endtask

    initial begin
        logic       seen_done;
        logic [1:0] rop;
        logic [W-1:0] ra, rb;

        Reset = 1'b1;
        bus.Start = 1'b0; bus.Op = 2'b00; bus.RegA = '0; bus.RegB = '0;
        repeat (2) @(negedge Clk);
        chk("rst.hi", 64'(bus.Hi), 64'd0);
        chk("rst.lo", 64'(bus.Lo), 64'd0);
        chk("rst.busy", 64'(bus.Busy), 64'd0);
        chk("rst.done", 64'(bus.Done), 64'd0);
        chk("rst.dbz", 64'(bus.divide_by_zero), 64'd0);
        Reset = 1'b0;
        exp_hi = '0; exp_lo = '0; exp_dbz = 1'b0;
        @(negedge Clk);

        run_op(OP_MULT,  32'hFFFFFFFD, 32'h00000007, -1, "t1_mult");
        chk("t1.hi_const", 64'(bus.Hi), 64'hFFFFFFFF);
        chk("t1.lo_const", 64'(bus.Lo), 64'hFFFFFFEB);
        run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, "t2_multu");
        chk("t2.hi_const", 64'(bus.Hi), 64'hFFFFFFFE);
        run_op(OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, -1, "t2_mult");
        run_op(OP_DIV,   32'hFFFFFFF9, 32'h00000002, -1, "t3_div");
        chk("t3.lo_const", 64'(bus.Lo), 64'hFFFFFFFD);
        run_op(OP_DIVU,  32'd100, 32'd7, -1, "t3_divu");
        run_op(OP_DIV,   32'd5, 32'd0, -1, "t4_dbz");
        chk("t4.hi_const", 64'(bus.Hi), 64'd2);
        chk("t4.lo_const", 64'(bus.Lo), 64'd14);
        run_op(OP_MULTU, 32'h12345678, 32'h9ABCDEF0, 5, "ignored_start");
        run_op(OP_DIV,   32'h80000000, 32'hFFFFFFFF, -1, "t5_minint");

        // Reset mid-operation, with a stray Start while busy.
        bus.Start = 1'b1; bus.Op = OP_MULT; bus.RegA = 32'd1234; bus.RegB = 32'd5678;
        @(negedge Clk);
        bus.Start = 1'b0;
        seen_done = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            bus.Start = (c == 5);
            Reset     = (c == 10);
            @(negedge Clk);
            seen_done = seen_done | bus.Done;
        end
        Reset = 1'b0; bus.Start = 1'b0;
        chk("t6.busy", 64'(bus.Busy), 64'd0);
        chk("t6.hi", 64'(bus.Hi), 64'd0);
        chk("t6.lo", 64'(bus.Lo), 64'd0);
        chk("t6.no_done", 64'(seen_done), 64'd0);
        exp_hi = '0; exp_lo = '0; exp_dbz = 1'b0;
        run_op(OP_MULT, 32'd1234, 32'd5678, -1, "t6_after");

        for (int i = 0; i < 30; i++) begin
            rop = 2'($urandom);
            ra  = W'($urandom);
            rb  = W'($urandom);
            if (($urandom % 6) == 0) rb = '0;
            if (($urandom % 8) == 0) ra = 32'h80000000;
            if (($urandom % 4) == 0) rb = W'($urandom_range(1, 15));
            run_op(rop, ra, rb, ((i % 3) == 0) ? 7 : -1, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
